// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage: size encodings,
// FSM states and the alignment rule.
package mem_access_pkg;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reserved size falls into the word rule.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~addr_lo[0];
      default:   is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables / data replication and
// load lane selection with sign or zero extension.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic        st_is_store,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: loads always enable the full word.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = st_wdata;
    if (st_is_store) begin
      case (st_size)
        SIZE_BYTE: begin
          be        = 4'b0001 << st_addr_lo;
          wdata_rep = {4{st_wdata[7:0]}};
        end
        SIZE_HALF: begin
          be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{st_wdata[15:0]}};
        end
        default: begin
          be        = 4'b1111;
          wdata_rep = st_wdata;
        end
      endcase
    end else begin
      be        = 4'b1111;
      wdata_rep = st_wdata;
    end
  end

  // Load side: pick the lane, then extend.
  always_comb begin
    byte_s = rdata[{ld_addr_lo, 3'b000} +: 8];
    half_s = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: ld_data = ld_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default:   ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data memory access controller: issues one request per aligned
// access, stalls the pipeline until ack or timeout, and returns load data.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic        is_load_r;
  logic        ld_unsigned_r;
  logic [1:0]  size_r;
  logic [1:0]  addr_lo_r;

  logic        access_s;
  logic        aligned_s;
  logic        issue_s;
  logic        timeout_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] ld_data_s;

  // Load steering uses the attributes latched at issue, not the live inputs.
  mem_align u_align (
    .st_size     (size),
    .st_addr_lo  (addr[1:0]),
    .st_is_store (mem_write),
    .st_wdata    (wdata),
    .be          (be_s),
    .wdata_rep   (wdata_rep_s),
    .ld_size     (size_r),
    .ld_addr_lo  (addr_lo_r),
    .ld_unsigned (ld_unsigned_r),
    .rdata       (dm_rdata),
    .ld_data     (ld_data_s)
  );

  // Request qualification and the combinational handshake to the pipeline.
  always_comb begin
    access_s  = mem_read | mem_write;
    aligned_s = is_aligned(size, addr[1:0]);
    issue_s   = (state_r == ST_IDLE) & access_s & aligned_s;
    timeout_s = (state_r == ST_WAIT) & ~dm_ack & (wait_cnt_r == WAIT_LAST);
    stall     = access_s & aligned_s & (state_r != ST_DONE);
    misalign  = (state_r == ST_IDLE) & access_s & ~aligned_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) state_nxt_s = ST_WAIT;
        else         state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (dm_ack || timeout_s) state_nxt_s = ST_DONE;
        else                     state_nxt_s = ST_WAIT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Bus outputs, wait counter and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= 32'h0000_0000;
      dm_be         <= 4'b0000;
      dm_wdata      <= 32'h0000_0000;
      rd_data       <= 32'h0000_0000;
      bus_err       <= 1'b0;
      wait_cnt_r    <= 8'd0;
      is_load_r     <= 1'b0;
      ld_unsigned_r <= 1'b0;
      size_r        <= 2'b00;
      addr_lo_r     <= 2'b00;
    end else begin
      bus_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            dm_req        <= 1'b1;
            dm_we         <= mem_write;
            dm_addr       <= {addr[31:2], 2'b00};
            dm_be         <= be_s;
            dm_wdata      <= wdata_rep_s;
            wait_cnt_r    <= 8'd0;
            is_load_r     <= ~mem_write;
            ld_unsigned_r <= ld_unsigned;
            size_r        <= size;
            addr_lo_r     <= addr[1:0];
          end
        end
        ST_WAIT: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (is_load_r) rd_data <= ld_data_s;
          end else if (timeout_s) begin
            dm_req  <= 1'b0;
            bus_err <= 1'b1;
            if (is_load_r) rd_data <= 32'h0000_0000;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        default: wait_cnt_r <= wait_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access with a byte-lane reference model.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] rd_data;
  logic        stall, misalign, bus_err;

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .rd_data(rd_data), .stall(stall), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        berr;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  logic [31:0] mis_q[$];
  logic [31:0] rd_model = 32'h0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input int nb, input logic [31:0] a);
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input int nb, input logic uns,
                                             input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v, mask;
    v = w >> (8 * (a % 4));
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  // ack_at: WAIT cycle (1-based) in which dm_ack is driven; 0 or >TMO means never
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdw, input int ack_at);
    int nb, stall_cnt, exp_stall;
    bit ok, tmo;
    req_t r;
    done_t d;
    nb  = nbytes(sz);
    ok  = (a % nb) == 0;
    tmo = (ack_at < 1) || (ack_at > TMO);
    if (ok) begin
      r.we        = wr;
      r.addr      = a - (a % 4);
      r.be        = wr ? model_be(nb, a) : 4'hF;
      r.wdata     = model_wdata(nb, wd);
      r.chk_wdata = wr;
      req_q.push_back(r);
      if (rd && !wr) rd_model = tmo ? 32'h0 : model_load(nb, uns, a, rdw);
      d.rd   = rd_model;
      d.berr = tmo;
      done_q.push_back(d);
    end else begin
      mis_q.push_back(rd_model);
    end
    mem_read = rd; mem_write = wr; size = sz; ld_unsigned = uns;
    addr = a; wdata = wd; dm_rdata = rdw;
    if (ok) begin
      exp_stall = tmo ? TMO + 1 : ack_at + 1;
      stall_cnt = 0;
      forever begin
        @(negedge clk);
        dm_ack = 1'b0;
        if (!stall) break;
        stall_cnt++;
        if (stall_cnt > TMO + 3) break;
        if (!tmo && stall_cnt == ack_at + 1) dm_ack = 1'b1;
      end
      dm_ack = 1'b0;
      chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    end else begin
      @(negedge clk);
      chk("misalign_stall", {31'h0, stall}, 32'h0);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic prev_req;
    req_t r;
    done_t d;
    logic [31:0] m;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (dm_req && !prev_req) begin
          if (req_q.size() == 0) chk("unexpected_req", 32'h1, 32'h0);
          else begin
            r = req_q.pop_front();
            chk("dm_we", {31'h0, dm_we}, {31'h0, r.we});
            chk("dm_addr", dm_addr, r.addr);
            chk("dm_be", {28'h0, dm_be}, {28'h0, r.be});
            if (r.chk_wdata) chk("dm_wdata", dm_wdata, r.wdata);
          end
        end
        if (!dm_req && prev_req) begin
          if (done_q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
          else begin
            d = done_q.pop_front();
            chk("rd_data", rd_data, d.rd);
            chk("bus_err", {31'h0, bus_err}, {31'h0, d.berr});
          end
        end else if (bus_err) begin
          chk("bus_err_spurious", 32'h1, 32'h0);
        end
        if (misalign) begin
          if (mis_q.size() == 0) chk("unexpected_misalign", 32'h1, 32'h0);
          else begin
            m = mis_q.pop_front();
            chk("misalign_rd_data", rd_data, m);
            chk("misalign_no_req", {31'h0, dm_req}, 32'h0);
          end
        end
        prev_req = dm_req;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [31:0] a;
    logic [1:0]  sz;
    int          pick;
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_dm_req", {31'h0, dm_req}, 32'h0);
    chk("reset_dm_addr", dm_addr, 32'h0);
    chk("reset_dm_be", {28'h0, dm_be}, 32'h0);
    chk("reset_dm_wdata", dm_wdata, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;

    // directed cases
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1);
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 2);
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 2);
    chk("half_load_unsigned", rd_data, 32'h0000_8001);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'hDEAD_BEEF, 1);
    do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 1);
    chk("rw_rd_unchanged", rd_data, 32'h0000_8001);

    // reset during the second WAIT cycle, late ack afterwards
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h0000_0050; r.be = 4'hF; r.wdata = 32'h0; r.chk_wdata = 1'b0;
      req_q.push_back(r);
      mem_read = 1'b1; size = 2'b10; addr = 32'h0000_0050;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      dm_ack = 1'b0;
      @(negedge clk);
      chk("rst_wait_dm_req", {31'h0, dm_req}, 32'h0);
      chk("rst_wait_rd_data", rd_data, 32'h0);
      chk("rst_wait_bus_err", {31'h0, bus_err}, 32'h0);
      rd_model = 32'h0;
      @(posedge clk); #1;
    end

    // timeout on a load after a nonzero result
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_FF00, 1);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 0);

    // random accesses
    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b00) a[1:0] = 2'b00;
      end
      do_access(pick != 1, pick != 0, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, TMO + 1));
    end

    repeat (3) @(posedge clk);
    chk("req_q_empty", 32'(req_q.size()), 32'h0);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    chk("mis_q_empty", 32'(mis_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for dm_ack before aborting with a bus error.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_read  input  1  load request from the EX/MEM register.
REQ-005 mem_write  input  1  store request from the EX/MEM register.
REQ-006 size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 ld_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 dm_req  output  1  memory request, registered.
REQ-011 dm_we  output  1  write strobe, valid with dm_req.
REQ-012 dm_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-013 dm_be  output  4  byte enables, little-endian lanes.
REQ-014 dm_wdata  output  32  lane-replicated store data.
REQ-015 dm_rdata  input  32  memory read word, valid with dm_ack.
REQ-016 dm_ack  input  1  memory completion, one cycle per request.
REQ-017 rd_data  output  32  aligned and extended load result, driven to MEM/WB rd input.
REQ-018 stall  output  1  holds all upstream pipeline registers while high.
REQ-019 misalign  output  1  one-cycle pulse on a misaligned access.
REQ-020 bus_err  output  1  one-cycle pulse on a timeout.

Function
REQ-021 The FSM has three states: IDLE, WAIT and DONE.
REQ-022 In IDLE, an aligned access causes dm_req and the other dm_* outputs to be registered, and the FSM moves to WAIT on the next edge.
REQ-023 In WAIT, dm_req, dm_we, dm_addr, dm_be and dm_wdata are held stable until dm_ack is sampled high.
REQ-024 When dm_ack is sampled high in WAIT, dm_req drops on that edge, the load result is captured into rd_data (loads only), and the FSM moves to DONE.
REQ-025 DONE lasts exactly one cycle and then returns to IDLE; back-to-back accesses are therefore separated by one IDLE cycle.
REQ-026 stall = (mem_read|mem_write) & aligned & (state != DONE); stall is combinational and is low in DONE so the pipeline advances.
REQ-027 The minimum latency is 3 cycles from the access in IDLE to the DONE cycle, for dm_ack arriving in the first WAIT cycle.
REQ-028 If mem_read and mem_write are both high, the write wins and the read is ignored.
REQ-029 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-030 A misaligned access issues no request, raises no stall, pulses misalign in that IDLE cycle, and leaves rd_data unchanged.
REQ-031 Store byte enables: byte access uses dm_be=1<<addr[1:0] with dm_wdata={4{wdata[7:0]}}; half access uses dm_be=addr[1]?1100:0011 with dm_wdata={2{wdata[15:0]}}; word access uses dm_be=1111 with dm_wdata=wdata.
REQ-032 Load lane select: byte uses dm_rdata[8*addr[1:0]+:8]; half uses the lane chosen by addr[1]; the selected value is sign- or zero-extended to 32 bits per ld_unsigned.
REQ-033 dm_be is 1111 for all loads.
REQ-034 rd_data holds its value until the next load completes; stores do not modify it.
REQ-035 An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
REQ-036 When the wait counter reaches TIMEOUT, dm_req drops, bus_err pulses, rd_data is set to 0 for a load, and the FSM moves to DONE.
REQ-037 dm_ack arriving in IDLE or DONE is ignored.

Reset
REQ-038 On rst the FSM goes to IDLE; dm_req, dm_we, misalign, bus_err and stall-driving state are cleared; dm_addr, dm_be, dm_wdata, rd_data and the wait counter are set to 0.
REQ-039 rst asserted during WAIT abandons the access, and a late dm_ack afterwards has no effect.

Structure
REQ-040 A shared package holds the size encodings, the FSM state enumeration and the TIMEOUT default.
REQ-041 The lane steering and extension logic (REQ-031 to REQ-033) are a combinational sub-module, mem_align.

Verification
REQ-042 Byte store: addr=0x1003, wdata=0xA5 -> dm_be=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x1000, stall high until DONE.
REQ-043 Signed half load: addr=0x2002, dm_rdata=0x8001_1234, dm_ack after 2 WAIT cycles -> rd_data=0xFFFF8001, stall high for exactly 3 cycles; the same access with ld_unsigned=1 -> rd_data=0x00008001.
REQ-044 Word load at addr=0x3001 -> misalign pulses 1 cycle, dm_req stays 0, stall stays 0, rd_data unchanged.
REQ-045 No dm_ack with TIMEOUT=4 -> bus_err pulses after 4 WAIT cycles, rd_data=0, FSM returns to IDLE.
REQ-046 rst asserted in the 2nd WAIT cycle, then dm_ack one cycle later -> dm_req=0, state IDLE, rd_data=0, no bus_err.
REQ-047 mem_read=mem_write=1 at addr=0x40 -> dm_we=1, dm_be=1111, rd_data unchanged.
